// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a maskable interrupt.
// Registers: CTRL (EN, MODE, IM), PRESET (reload value) and COUNT (read-only live count).
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_flag_q, irq_flag_d;

    logic [1:0]         reg_sel;
    logic               ctrl_wr;
    logic               preset_wr;
    logic               auto_reload;
    logic               count_gt1;
    logic               unused_addr_bits;

    assign reg_sel          = addr[3:2];
    assign ctrl_wr          = we && (reg_sel == 2'd0);
    assign preset_wr        = we && (reg_sel == 2'd1);
    // MODE values 1x fall back to one-shot behaviour.
    assign auto_reload      = (mode_q == 2'b01);
    assign count_gt1        = (count_q > CNT_W'(1));
    assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (!count_gt1) begin
                    state_d = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath updates driven by the FSM; a CPU CTRL write then overrides EN/MODE/IM and irq_flag.
    always_comb begin
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_LOAD: begin
                count_d = preset_q;
            end
            S_CNT: begin
                if (en_q) begin
                    if (count_gt1) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d    = '0;
                        irq_flag_d = 1'b1;
                    end
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    en_d = 1'b0;
                end
            end
            default: begin
            end
        endcase

        if (ctrl_wr) begin
            en_d       = din[0];
            mode_d     = din[2:1];
            im_d       = din[3];
            irq_flag_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = din[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Read mux and interrupt output
    always_comb begin
        dout = 32'h0;
        case (reg_sel)
            2'd0:    dout = {28'h0, im_q, mode_q, en_q};
            2'd1:    dout = 32'(preset_q);
            2'd2:    dout = 32'(count_q);
            default: dout = 32'h0;
        endcase
    end

    assign irq = irq_flag_q & im_q;

endmodule
